uart_tx_arb: RTL and testbench

Shares the single UART transmitter (rxtx, 9600 baud / 25 MHz, even parity) between NREQ byte-stream requesters.
- Grants the transmitter to one requester per frame; a frame ends on the byte flagged last.
- Optionally prefixes each frame with a tag byte that identifies the requester.
- Paces bytes on txrdy and drives the transmitter's tx_vld/tx_data.
- Sits between the firmware/peripheral byte sources and the rxtx tx port.

---
 rtl/uart_pkg.sv | 25 ++
 rtl/rr_pick.sv | 34 +++
 rtl/uart_tx_arb.sv | 184 ++++++++++++++++++
 tb/tb_uart_tx_arb.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter FSM states, default tag base and the
// line timing constants used by rxtx, the arbiter and the bench.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TAG   = 2'd1,
    SEND  = 2'd2,
    GUARD = 2'd3
  } arb_state_e;

  localparam logic [7:0] DEFAULT_TAG_BASE = 8'hA0;

  // 9600 baud from a 25 MHz clock, 11-bit frames (start, 8 data, parity, stop).
  localparam int BAUD       = 9600;
  localparam int MHZ        = 25;
  localparam int BIT_CYC    = MHZ * 1000000 / BAUD;
  localparam int FRAME_BITS = 11;

  // Even parity bit as sent by rxtx for a data byte.
  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin priority picker.
//   req    : N request bits
//   ptr    : index searched first; search continues upward with wrap
//   onehot : one-hot winner (0 when no request)
//   idx    : winner index
//   valid  : any request present
module rr_pick #(
  parameter  int N  = 2,
  localparam int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          valid
);

  always_comb begin
    int j;
    j      = 0;
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    for (int k = 0; k < N; k++) begin
      j = (int'(ptr) + k) % N;
      if (!valid && req[j]) begin
        valid     = 1'b1;
        onehot[j] = 1'b1;
        idx       = IW'(j);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arb.sv
// Shares one UART transmitter between NREQ byte-stream requesters.
// Ownership is granted per frame (ended by req_last), optionally prefixed
// with a tag byte TAG_BASE+owner. Bytes are paced on txrdy; after each
// strobe txrdy is ignored for GUARD_CYC cycles while the transmitter's busy
// flag catches up. An owner that stalls mid-frame for TIMEOUT cycles is
// forcibly released with a one-cycle err_timeout pulse.
// Ports:
//   clk, rst_n     : clock, async active-low reset
//   req_vld/data/last/rdy : per-requester byte stream (data at [8i+7:8i])
//   txrdy          : transmitter idle
//   tx_vld/tx_data : one-cycle byte strobe and byte to the transmitter
//   grant          : one-hot owner, 0 when idle
//   err_timeout    : pulse on forced release
module uart_tx_arb
  import uart_pkg::*;
#(
  parameter int         NREQ      = 2,
  parameter bit         TAG_EN    = 1'b1,
  parameter logic [7:0] TAG_BASE  = DEFAULT_TAG_BASE,
  parameter int         GUARD_CYC = 2,
  parameter int         TIMEOUT   = 1000000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_vld,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_rdy,
  input  logic              txrdy,
  output logic              tx_vld,
  output logic [7:0]        tx_data,
  output logic [NREQ-1:0]   grant,
  output logic              err_timeout
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int GC = (GUARD_CYC > 1) ? GUARD_CYC : 1;
  localparam int GW = (GC > 1) ? $clog2(GC) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] G_LAST  = GW'(GC - 1);

  arb_state_e      state_q, state_d;
  arb_state_e      ret_q, ret_d;
  logic [NREQ-1:0] grant_d;
  logic [IW-1:0]   own_q, own_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [GW-1:0]   gcnt_q, gcnt_d;
  logic [TW-1:0]   tocnt_q, tocnt_d;
  logic            tx_vld_d;
  logic [7:0]      tx_data_d;
  logic            err_d;

  logic [NREQ-1:0] pick_oh;
  logic [IW-1:0]   pick_idx;
  logic            pick_vld;

  logic            own_vld;
  logic            own_last;
  logic [7:0]      own_data;
  logic [IW-1:0]   own_inc;
  logic [TW-1:0]   tocnt_inc;

  rr_pick #(.N(NREQ)) u_pick (
    .req    (req_vld),
    .ptr    (rr_q),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .valid  (pick_vld)
  );

  // Owner's stream, selected by the registered owner index.
  always_comb begin
    own_vld  = 1'b0;
    own_last = 1'b0;
    own_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (own_q == IW'(i)) begin
        own_vld  = req_vld[i];
        own_last = req_last[i];
        own_data = req_data[8*i +: 8];
      end
    end
  end

  assign own_inc   = (own_q == IW'(NREQ - 1)) ? '0 : own_q + 1'b1;
  // Saturating idle counter: never wraps back into the legal range.
  assign tocnt_inc = (tocnt_q == '1) ? tocnt_q : tocnt_q + 1'b1;

  assign req_rdy = (state_q == SEND && txrdy) ? (grant & req_vld) : '0;

  always_comb begin
    state_d   = state_q;
    ret_d     = ret_q;
    grant_d   = grant;
    own_d     = own_q;
    rr_d      = rr_q;
    gcnt_d    = gcnt_q;
    tocnt_d   = tocnt_q;
    tx_vld_d  = 1'b0;
    tx_data_d = tx_data;
    err_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_vld) begin
          grant_d = pick_oh;
          own_d   = pick_idx;
          tocnt_d = '0;
          state_d = TAG_EN ? TAG : SEND;
        end
      end
      TAG: begin
        if (txrdy) begin
          tx_vld_d  = 1'b1;
          tx_data_d = TAG_BASE + 8'(own_q);
          ret_d     = SEND;
          gcnt_d    = '0;
          state_d   = GUARD;
        end
      end
      SEND: begin
        if (own_vld && txrdy) begin
          tx_vld_d  = 1'b1;
          tx_data_d = own_data;
          ret_d     = own_last ? IDLE : SEND;
          gcnt_d    = '0;
          tocnt_d   = '0;
          state_d   = GUARD;
        end else if (!own_vld) begin
          if (tocnt_q >= TO_LAST) begin
            err_d   = 1'b1;
            grant_d = '0;
            rr_d    = own_inc;
            state_d = IDLE;
          end else begin
            tocnt_d = tocnt_inc;
          end
        end
      end
      GUARD: begin
        // Owner idleness keeps accruing here so the timeout is measured
        // from the accepted byte, not from the end of the guard window.
        if (!own_vld) tocnt_d = tocnt_inc;
        if (gcnt_q == G_LAST) begin
          state_d = ret_q;
          if (ret_q == IDLE) begin
            grant_d = '0;
            rr_d    = own_inc;
          end
        end else begin
          gcnt_d = gcnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ret_q       <= IDLE;
      grant       <= '0;
      own_q       <= '0;
      rr_q        <= '0;
      gcnt_q      <= '0;
      tocnt_q     <= '0;
      tx_vld      <= 1'b0;
      tx_data     <= '0;
      err_timeout <= 1'b0;
    end else begin
      state_q     <= state_d;
      ret_q       <= ret_d;
      grant       <= grant_d;
      own_q       <= own_d;
      rr_q        <= rr_d;
      gcnt_q      <= gcnt_d;
      tocnt_q     <= tocnt_d;
      tx_vld      <= tx_vld_d;
      tx_data     <= tx_data_d;
      err_timeout <= err_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Bench for uart_tx_arb: queue-driven requesters, a simple transmitter model
// (txrdy falls one cycle after a strobe and stays low for byte_cyc cycles),
// and a round-robin frame-order reference model.
module tb_uart_tx_arb;
  import uart_pkg::*;

  localparam int         NREQ     = 3;
  localparam logic [7:0] TBASE    = 8'hA0;
  localparam int         GUARD    = 2;
  localparam int         TOUT     = 1000;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [NREQ-1:0]     req_vld = '0;
  logic [8*NREQ-1:0]   req_data = '0;
  logic [NREQ-1:0]     req_last = '0;
  logic [NREQ-1:0]     req_rdy;
  logic                txrdy = 1'b1;
  logic                tx_vld;
  logic [7:0]          tx_data;
  logic [NREQ-1:0]     grant;
  logic                err_timeout;

  uart_tx_arb #(
    .NREQ(NREQ), .TAG_EN(1'b1), .TAG_BASE(TBASE),
    .GUARD_CYC(GUARD), .TIMEOUT(TOUT)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .req_vld(req_vld), .req_data(req_data), .req_last(req_last), .req_rdy(req_rdy),
    .txrdy(txrdy), .tx_vld(tx_vld), .tx_data(tx_data),
    .grant(grant), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  int ncmp = 0, nfail = 0;
  int cyc = 0;
  logic [8:0]      rq [NREQ][$];   // {last, byte}
  int              gap [NREQ];
  int              acc_cyc [NREQ];
  bit              rnd_gap = 1'b0;
  logic [7:0]      txq[$];
  int              stq[$];
  logic [NREQ-1:0] gq[$];
  logic [7:0]      exp_b[$];
  logic [NREQ-1:0] exp_g[$];
  int              nerr = 0, err_cyc = -1, viol = 0;
  int              byte_cyc = 8, busy = 0;
  bit              start = 1'b0;
  logic [NREQ-1:0] fire = '0;
  logic            prev_vld = 1'b0;
  logic [NREQ-1:0] prev_grant = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    logic [8:0] e;
    for (int i = 0; i < NREQ; i++) begin
      if (rq[i].size() > 0 && gap[i] == 0) begin
        e = rq[i][0];
        req_vld[i] = 1'b1; req_data[8*i +: 8] = e[7:0]; req_last[i] = e[8];
      end else begin
        req_vld[i] = 1'b0; req_data[8*i +: 8] = 8'h00; req_last[i] = 1'b0;
      end
    end
  endtask

  // Observation at the falling edge, away from the active edge.
  always @(negedge clk) begin
    fire = req_rdy & req_vld;
    for (int i = 0; i < NREQ; i++) if (fire[i]) acc_cyc[i] = cyc + 1;
    if (rst_n) begin
      if (tx_vld) begin
        txq.push_back(tx_data);
        stq.push_back(cyc);
        if (!txrdy || prev_vld) viol++;
        start = 1'b1;
      end
      if (err_timeout) begin nerr++; err_cyc = cyc; end
      if (grant != prev_grant && grant != '0) gq.push_back(grant);
      if (grant != '0 && !$onehot(grant)) viol++;
    end
    prev_vld = tx_vld;
    prev_grant = grant;
  end

  // Transmitter model and requester drivers, updated just after the edge.
  always @(posedge clk) begin
    logic [8:0] e;
    cyc++;
    #1;
    if (!rst_n) begin
      txrdy = 1'b1; busy = 0; start = 1'b0; fire = '0;
    end else if (start) begin
      start = 1'b0; txrdy = 1'b0; busy = byte_cyc;
    end else if (busy > 0) begin
      busy--;
      if (busy == 0) txrdy = 1'b1;
    end
    for (int i = 0; i < NREQ; i++) begin
      if (fire[i] && rq[i].size() > 0) begin
        e = rq[i].pop_front();
        if (!e[8] && rnd_gap) gap[i] = $urandom_range(0, 4);
      end else if (gap[i] > 0) begin
        gap[i]--;
      end
    end
    fire = '0;
    drive();
  end

  // Expected byte stream and grant order: frames go whole, one at a time,
  // to the first requester with pending data at or after the pointer.
  task automatic build_model();
    logic [8:0]      mq [NREQ][$];
    logic [8:0]      e;
    logic [NREQ-1:0] one;
    int ptr, w;
    one = 1;
    ptr = 0;
    exp_b.delete(); exp_g.delete();
    for (int i = 0; i < NREQ; i++) mq[i] = rq[i];
    w = 0;
    while (w >= 0) begin
      w = -1;
      for (int k = 0; k < NREQ; k++)
        if (w < 0 && mq[(ptr + k) % NREQ].size() > 0) w = (ptr + k) % NREQ;
      if (w >= 0) begin
        exp_g.push_back(one << w);
        exp_b.push_back(TBASE + 8'(w));
        e = 9'h000;
        while (!e[8] && mq[w].size() > 0) begin
          e = mq[w].pop_front();
          exp_b.push_back(e[7:0]);
        end
        ptr = (w + 1) % NREQ;
      end
    end
  endtask

  task automatic hold_reset();
    #2;
    rst_n = 1'b0;
    for (int i = 0; i < NREQ; i++) begin rq[i].delete(); gap[i] = 0; acc_cyc[i] = -1; end
    txq.delete(); stq.delete(); gq.delete();
    nerr = 0; err_cyc = -1; viol = 0;
    drive();
    repeat (2) @(negedge clk);
  endtask

  task automatic release_reset();
    drive();
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  task automatic add(input int i, input logic [7:0] b, input bit last);
    rq[i].push_back({last, b});
  endtask

  task automatic wait_bytes(input string tag, input int n, input int budget);
    int t;
    t = 0;
    while (txq.size() < n && t < budget) begin @(negedge clk); t++; end
    chk({tag, ".done_in_budget"}, 32'(txq.size() >= n), 32'd1);
    repeat (byte_cyc + 20) @(negedge clk);
  endtask

  task automatic chk_stream(input string tag);
    chk({tag, ".len"}, txq.size(), exp_b.size());
    for (int k = 0; k < exp_b.size() && k < txq.size(); k++)
      chk($sformatf("%s.byte[%0d]", tag, k), 32'(txq[k]), 32'(exp_b[k]));
    chk({tag, ".grant_len"}, gq.size(), exp_g.size());
    for (int k = 0; k < exp_g.size() && k < gq.size(); k++)
      chk($sformatf("%s.grant[%0d]", tag, k), 32'(gq[k]), 32'(exp_g[k]));
    chk({tag, ".idle_grant"}, 32'(grant), 32'd0);
    chk({tag, ".protocol"}, viol, 0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int minsp, n;

    // Reset state, with a request already waiting.
    hold_reset();
    add(0, 8'h5A, 1'b1);
    drive();
    @(negedge clk);
    chk("rst.tx_vld", 32'(tx_vld), 32'd0);
    chk("rst.tx_data", 32'(tx_data), 32'd0);
    chk("rst.grant", 32'(grant), 32'd0);
    chk("rst.err_timeout", 32'(err_timeout), 32'd0);
    chk("rst.req_rdy", 32'(req_rdy), 32'd0);

    // Single one-byte frame: tag then data, both even-parity 0.
    build_model();
    release_reset();
    wait_bytes("single", 2, 200);
    chk_stream("single");
    chk("single.tag", 32'(txq[0]), 32'hA0);
    chk("single.data", 32'(txq[1]), 32'h5A);
    chk("single.parity0", 32'(even_parity(txq[0])), 32'd0);
    chk("single.parity1", 32'(even_parity(txq[1])), 32'd0);

    // Contention from reset: whole frame of req0, then req1.
    hold_reset();
    add(0, 8'h11, 1'b0); add(0, 8'h22, 1'b1); add(1, 8'h33, 1'b1);
    build_model();
    release_reset();
    wait_bytes("contend", exp_b.size(), 400);
    chk_stream("contend");
    chk("contend.tag1", 32'(txq[3]), 32'hA1);

    // Round-robin fairness over one-byte frames.
    hold_reset();
    for (int f = 0; f < 3; f++) begin add(0, 8'h01, 1'b1); add(1, 8'h02, 1'b1); end
    build_model();
    release_reset();
    wait_bytes("rr", exp_b.size(), 800);
    chk_stream("rr");

    // Pacing against a slow transmitter.
    byte_cyc = 30;
    hold_reset();
    add(2, 8'hC1, 1'b0); add(2, 8'hC2, 1'b0); add(2, 8'hC3, 1'b1);
    build_model();
    release_reset();
    wait_bytes("pace", exp_b.size(), 600);
    chk_stream("pace");
    minsp = 1 << 30;
    for (int k = 1; k < stq.size(); k++) if (stq[k] - stq[k-1] < minsp) minsp = stq[k] - stq[k-1];
    chk("pace.min_spacing_ok", 32'(minsp >= byte_cyc + 1), 32'd1);

    // Owner stalls mid-frame: forced release, waiting requester proceeds.
    byte_cyc = 8;
    hold_reset();
    add(0, 8'h10, 1'b0); add(1, 8'h20, 1'b1);
    build_model();
    release_reset();
    wait_bytes("timeout", exp_b.size(), TOUT + 400);
    chk_stream("timeout");
    chk("timeout.pulses", nerr, 1);
    chk("timeout.delay", err_cyc - acc_cyc[0], TOUT);

    // Reset asserted in the guard window after the tag strobe.
    hold_reset();
    add(0, 8'hAA, 1'b0); add(0, 8'hBB, 1'b1);
    release_reset();
    n = 0;
    while (txq.size() < 1 && n < 200) begin @(negedge clk); n++; end
    chk("rstmid.tag_seen", txq.size(), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstmid.tx_vld", 32'(tx_vld), 32'd0);
    chk("rstmid.grant", 32'(grant), 32'd0);
    repeat (2) @(negedge clk);
    chk("rstmid.no_strobe", txq.size(), 1);
    hold_reset();
    add(1, 8'h77, 1'b1);
    build_model();
    release_reset();
    wait_bytes("rstmid", exp_b.size(), 200);
    chk_stream("rstmid");

    // Randomized frames with mid-frame stalls and varying byte time.
    rnd_gap = 1'b1;
    for (int it = 0; it < 6; it++) begin
      byte_cyc = $urandom_range(3, 20);
      hold_reset();
      for (int i = 0; i < NREQ; i++) begin
        int nf;
        nf = $urandom_range(0, 3);
        for (int f = 0; f < nf; f++) begin
          int len;
          len = $urandom_range(1, 4);
          for (int b = 0; b < len; b++) add(i, 8'($urandom), b == len - 1);
        end
      end
      if (rq[0].size() == 0 && rq[1].size() == 0 && rq[2].size() == 0) add(1, 8'h5C, 1'b1);
      build_model();
      release_reset();
      wait_bytes($sformatf("rand%0d", it), exp_b.size(), 400 + exp_b.size() * (byte_cyc + 20));
      chk_stream($sformatf("rand%0d", it));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
